// File: rtl/lsu_memory.sv
// lsu_memory: single-ported word memory behind a load/store request/response
// handshake. One request is outstanding at a time. Loads return byte, half
// or word data (sign- or zero-extended) after READ_LATENCY cycles. Stores and
// rejected requests answer after one cycle.
//
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   req_valid/req_ready - request handshake (ready only while idle)
//   req_write           - 1 = store, 0 = load
//   req_size            - 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        - loads zero-extend when 1, sign-extend when 0
//   req_addr, req_wdata - byte address, store data (low bits used)
//   resp_valid/ready    - response handshake
//   resp_rdata          - load result, 0 for stores and errors
//   resp_error          - request was rejected (bad size, misaligned, range)
//   initial_values      - storage contents loaded while reset is high
//   memory_check        - live storage contents
module lsu_memory #(
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_error,
  input  logic [DEPTH-1:0][31:0] initial_values,
  output logic [DEPTH-1:0][31:0] memory_check
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][31:0] storage;
  logic                   accept;
  logic                   req_err;
  logic [IDX_W-1:0]       idx;
  logic [3:0]             wmask;
  logic [31:0]            wlanes;

  logic [31:0]            word_p1;
  logic [1:0]             size_p1;
  logic [1:0]             lane_p1;
  logic                   uns_p1;
  logic                   err_p1;
  logic                   load_p1;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    lane_mask = 4'b0001 << lo;
      2'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Replicate the low store bits across the word so any lane can pick them up.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    store_lanes = {4{wdata[7:0]}};
      2'd1:    store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b  = word[8*lo +: 8];
    h  = lo[1] ? word[31:16] : word[15:0];
    bx = b;
    hx = h;
    case (size)
      2'd0:    load_extract = uns ? {24'd0, b} : bx;
      2'd1:    load_extract = uns ? {16'd0, h} : hx;
      default: load_extract = word;
    endcase
  endfunction

  // Upper address bits only feed the range check, so they can never alias
  // back into the storage array.
  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                || (req_addr[31:2] >= 30'(DEPTH));

  assign idx       = req_addr[IDX_W+1:2];
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign wmask     = lane_mask(req_size, req_addr[1:0]);
  assign wlanes    = store_lanes(req_size, req_wdata);

  // Stage p0: request accept; storage write and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      storage <= initial_values;
    end else if (accept && req_write && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) storage[idx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || req_write || READ_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(READ_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: request fields and the addressed word, frozen for the response.
  // Not reset: every use is gated by the RESP state.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p1 <= storage[idx];
      size_p1 <= req_size;
      lane_p1 <= req_addr[1:0];
      uns_p1  <= req_unsigned;
      err_p1  <= req_err;
      load_p1 <= !req_write && !req_err;
    end
  end

  assign resp_valid   = (state_q == RESP);
  assign resp_error   = resp_valid && err_p1;
  assign resp_rdata   = (resp_valid && load_p1) ? load_extract(word_p1, size_p1, lane_p1, uns_p1) : 32'd0;
  assign memory_check = storage;

endmodule

// File: tb/tb_lsu_memory.sv
// Bench for lsu_memory: two instances (READ_LATENCY 1 and 3) share request
// fields; a byte-array reference model supplies every expected value.
module tb_lsu_memory;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                   req_write = 1'b0;
  logic [1:0]             req_size = 2'd0;
  logic                   req_unsigned = 1'b0;
  logic [31:0]            req_addr = 32'd0;
  logic [31:0]            req_wdata = 32'd0;
  logic                   resp_ready = 1'b0;
  logic [DEPTH-1:0][31:0] init_vals;

  logic                   req_valid_a  [2];
  logic                   req_ready_a  [2];
  logic                   resp_valid_a [2];
  logic                   resp_error_a [2];
  logic [31:0]            resp_rdata_a [2];
  logic [DEPTH-1:0][31:0] mem_chk      [2];

  logic [7:0] mb [2][4*DEPTH];
  int n_checks = 0;
  int n_fail = 0;

  lsu_memory #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[0]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a[0]), .resp_error(resp_error_a[0]),
    .initial_values(init_vals), .memory_check(mem_chk[0])
  );

  lsu_memory #(.DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a[1]), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a[1]), .resp_error(resp_error_a[1]),
    .initial_values(init_vals), .memory_check(mem_chk[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int d, input int i);
    return {mb[d][4*i+3], mb[d][4*i+2], mb[d][4*i+1], mb[d][4*i]};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        for (int b = 0; b < 4; b++)
          mb[d][4*i+b] = init_vals[i][8*b +: 8];
  endfunction

  // Byte-addressed model: an access covers 2**size consecutive bytes.
  function automatic void model(input int d, input bit wr, input int sz, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output bit err, output logic [31:0] rd);
    int n;
    longint v;
    err = (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0)
       || (addr / 4 >= DEPTH);
    rd = 32'd0;
    if (err) return;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) mb[d][addr+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mb[d][addr+i]) << (8*i);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
      rd = v[31:0];
    end
  endfunction

  task automatic mem_cmp(input int d);
    for (int i = 0; i < DEPTH; i++) check("memory_check", mem_chk[d][i], model_word(d, i));
  endtask

  // Called between a negedge and the following posedge.
  task automatic xact(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          lat;
    int          exp_lat;
    model(d, wr, int'(sz), uns, addr, wd, exp_err, exp_rd);
    exp_lat = (wr || exp_err) ? 1 : ((d == 1) ? 3 : 1);
    check("ready_idle", 32'(req_ready_a[d]), 32'd1);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid_a[d] = 1'b1;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: the response must not depend on them now.
    req_valid_a[d] = 1'($urandom_range(0, 1));
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid_a[d] && lat < 12) begin
      check("ready_busy", 32'(req_ready_a[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    rd = resp_rdata_a[d];
    check("rdata", resp_rdata_a[d], exp_rd);
    check("error", 32'(resp_error_a[d]), 32'(exp_err));
    check("ready_resp", 32'(req_ready_a[d]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid_a[d]), 32'd1);
      check("hold_rdata", resp_rdata_a[d], exp_rd);
      check("hold_error", 32'(resp_error_a[d]), 32'(exp_err));
      check("hold_ready", 32'(req_ready_a[d]), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid_a[d] = 1'b0;
    check("release_valid", 32'(resp_valid_a[d]), 32'd0);
    check("release_ready", 32'(req_ready_a[d]), 32'd1);
    mem_cmp(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          d;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) init_vals[i] = $urandom;
    init_vals[1] = 32'h8899AABB;
    req_valid_a[0] = 1'b0;
    req_valid_a[1] = 1'b0;
    model_reset();

    #1 reset = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(req_ready_a[k]), 32'd0);
      check("rst_valid", 32'(resp_valid_a[k]), 32'd0);
      check("rst_rdata", resp_rdata_a[k], 32'd0);
      check("rst_error", 32'(resp_error_a[k]), 32'd0);
      mem_cmp(k);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_rst0", 32'(req_ready_a[0]), 32'd1);
    check("ready_after_rst1", 32'(req_ready_a[1]), 32'd1);

    // Directed loads and stores on the latency-1 instance
    xact(0, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 0, rd);
    check("ld_word4", rd, 32'h8899AABB);
    xact(0, 1'b0, 2'd0, 1'b0, 32'd7, 32'd0, 1, rd);
    check("ld_sbyte7", rd, 32'hFFFFFF88);
    xact(0, 1'b0, 2'd1, 1'b1, 32'd6, 32'd0, 0, rd);
    check("ld_uhalf6", rd, 32'h00008899);
    xact(0, 1'b1, 2'd0, 1'b0, 32'd5, 32'h1234565A, 1, rd);
    check("st_byte_rdata", rd, 32'd0);
    check("st_byte_mem1", mem_chk[0][1], 32'h88995ABB);
    xact(0, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 0, rd);
    check("ld_after_st", rd, 32'h88995ABB);
    xact(0, 1'b1, 2'd2, 1'b0, 32'd6, 32'hDEADBEEF, 2, rd);
    check("st_misaligned_err", 32'(resp_error_a[0]), 32'd0);
    xact(0, 1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'd0, 0, rd);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h80000004, 32'h01020304, 0, rd);
    xact(0, 1'b0, 2'd3, 1'b0, 32'd0, 32'd0, 0, rd);

    // Latency 3 with backpressure
    xact(1, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 5, rd);
    check("ld3_word4", rd, 32'h8899AABB);
    xact(1, 1'b0, 2'd0, 1'b1, 32'd7, 32'd0, 2, rd);
    check("ld3_ubyte7", rd, 32'h00000088);
    xact(1, 1'b1, 2'd1, 1'b0, 32'd3, 32'h0000BEEF, 0, rd);

    // Randomized traffic on both instances
    for (int t = 0; t < 200; t++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = $urandom_range(0, 4*DEPTH + 7);
      xact(d, 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
           int'($urandom_range(0, 3)), rd);
    end

    // Reset while a latency-3 load waits; an earlier store is undone
    xact(1, 1'b1, 2'd2, 1'b0, 32'd8, 32'hCAFEF00D, 0, rd);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'd8;
    req_valid_a[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[1] = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rstw_ready", 32'(req_ready_a[1]), 32'd0);
    check("rstw_valid", 32'(resp_valid_a[1]), 32'd0);
    check("rstw_rdata", resp_rdata_a[1], 32'd0);
    check("rstw_error", 32'(resp_error_a[1]), 32'd0);
    model_reset();
    mem_cmp(0);
    mem_cmp(1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstw_no_pulse", 32'(resp_valid_a[1]), 32'd0);
      check("rstw_ready_back", 32'(req_ready_a[1]), 32'd1);
    end

    // Reset while a response is presented: valid must drop without a clock
    req_write = 1'b0; req_size = 2'd2; req_addr = 32'd4;
    req_valid_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    check("rstr_valid_before", 32'(resp_valid_a[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstr_valid", 32'(resp_valid_a[0]), 32'd0);
    check("rstr_rdata", resp_rdata_a[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstr_no_pulse", 32'(resp_valid_a[0]), 32'd0);
    end
    xact(1, 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 0, rd);
    xact(0, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0, 0, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_memory.md
LSU_MEMORY -- requirements
Module: lsu_memory

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DEPTH, 32, number of 32-bit words.
- READ_LATENCY, 1, cycles from read accept to resp_valid; legal range 1..4.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state on its rising edge.
- reset, in, 1, asynchronous, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned, in, 1, load zero-extends when 1 and sign-extends when 0.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, taken from the low bits.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, consumer accepts the response.
- resp_rdata, out, 32, load result; 0 for stores and errors.
- resp_error, out, 1, request was rejected.
- initial_values, in, DEPTH x 32, contents loaded during reset.
- memory_check, out, DEPTH x 32, live contents for the bench.

Function
REQ-003 Storage SHALL be DEPTH words, little-endian; word index = req_addr[31:2]; byte lane = req_addr[1:0].
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-006 An accepted request SHALL be an error when any of the following holds: req_size = 3; req_size = 1 and addr[0] = 1; req_size = 2 and addr[1:0] != 0; word index >= DEPTH.
REQ-007 An error or store request SHALL go IDLE -> RESP on the accept edge; resp_valid is high the next cycle (latency 1).
REQ-008 A store with no error SHALL update memory on the accept edge, touching only the addressed lanes:
- byte: lane addr[1:0] takes wdata[7:0].
- half: lanes addr[1]*2 and +1 take wdata[15:0].
- word: all four lanes.
REQ-009 An erroring store SHALL leave memory unchanged.
REQ-010 A non-error load SHALL capture the addressed word on the accept edge.
- READ_LATENCY = 1: go directly to RESP.
- Otherwise: go to WAIT with counter = READ_LATENCY-1, decrement each cycle, and enter RESP when the counter reaches 1.
- resp_valid SHALL rise exactly READ_LATENCY cycles after the accept edge.
REQ-011 Load data SHALL be extracted from the captured word (not re-read from memory).
- byte: lane addr[1:0], extended per req_unsigned.
- half: lanes per addr[1], extended per req_unsigned.
- word: unmodified.
REQ-012 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until an edge with resp_ready = 1; that edge moves the FSM to IDLE and clears resp_valid.
REQ-013 Only one request SHALL be outstanding; req_valid outside IDLE has no effect and req_* may change freely then.
REQ-014 Address, size and unsigned fields SHALL be registered at accept; the response never depends on req_* after accept.
REQ-015 memory_check[i] SHALL equal storage word i combinationally at all times.
REQ-016 Address bits above the index range SHALL only cause an error per REQ-006 and SHALL never wrap into storage.

Reset
REQ-017 While reset = 1 (asynchronously on assertion), outputs SHALL be:
- FSM = IDLE, counter = 0.
- req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0.
- storage[i] = initial_values[i] for every i.
REQ-018 req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-019 Reset asserted in WAIT or RESP SHALL drop the pending response with no resp_valid pulse; a store already accepted stays overwritten by initial_values.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Load word: init word 1 = 0x8899AABB; load word, addr 4, READ_LATENCY = 1 -> resp_valid 1 cycle after accept; rdata 0x8899AABB; error 0.
- Byte loads: signed byte load, addr 7 -> rdata 0xFFFFFF88; unsigned half load, addr 6 -> 0x00008899.
- Byte store then read: store byte 0x5A at addr 5 -> memory_check[1] = 0x8899 5A BB (0x88995ABB); following word load returns the same value.
- Misaligned or out-of-range: word store addr 0x6 -> resp_error 1, rdata 0, memory unchanged; load addr 4*DEPTH -> resp_error 1.
- Latency and backpressure: READ_LATENCY = 3, resp_ready held 0 for 5 cycles -> resp_valid rises exactly 3 cycles after accept; rdata/error stable throughout; req_ready 0 until the cycle after the resp_ready edge.
- Reset mid-operation: reset asserted in WAIT -> outputs clear immediately without a clock; memory equals initial_values; no response pulse after release.
